// File: rtl/keypad_event_queue.sv
// keypad_event_queue: debounces the 24-bit scanner vector, turns new hex-key
// presses into 4-bit codes queued in a small FIFO (valid/ready), and exposes
// the debounced switch levels.
module keypad_event_queue #(
  parameter int unsigned SAMPLE_DIV = 1024,
  parameter int unsigned STABLE     = 3,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [23:0] button,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_down,
  output logic [7:0]  switches,
  output logic        overflow,
  input  logic        clr_ovf
);

  localparam int unsigned PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [3:0]    CNT_LAST = 4'(STABLE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  logic [23:0]   deb_q, deb_d;
  logic [3:0]    cnt_q [24];
  logic [3:0]    cnt_d [24];

  logic [15:0]   rise;
  logic          push;
  logic [3:0]    push_code;

  logic [3:0]    mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, wr, drop;

  // Sample prescaler: free-running 0..SAMPLE_DIV-1, tick on the last count
  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Prescaler register
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) pre_q <= '0;
    else         pre_q <= pre_d;
  end

  // Per-bit debounce: deb flips after STABLE consecutive differing samples
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 24; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (button[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = button[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < 24; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int unsigned i = 0; i < 24; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Press detection: lowest-index rising hex key wins, others are discarded
  always_comb begin
    rise      = deb_d[15:0] & ~deb_q[15:0];
    push      = 1'b0;
    push_code = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (rise[i] && !push) begin
        push      = 1'b1;
        push_code = 4'(i);
      end
    end
  end

  // FIFO control: pointers carry a wrap bit; a pop frees a slot for a same-cycle push
  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop    = !empty && key_ready;
    wr     = push && (!full || pop);
    drop   = push && full && !pop;
    wptr_d = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    ovf_d  = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // FIFO storage, pointers and sticky overflow
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      if (wr) mem_q[wptr_q[AW-1:0]] <= push_code;
    end
  end

  // Outputs come from registered state only
  always_comb begin
    key_code  = mem_q[rptr_q[AW-1:0]];
    key_valid = !empty;
    key_down  = |deb_q[15:0];
    switches  = deb_q[23:16];
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_keypad_event_queue.sv
// Self-checking bench for keypad_event_queue (SAMPLE_DIV=4, STABLE=3, DEPTH=4).
// Expected key codes are queued when a press is driven and compared on each
// accepted handshake.
module tb_keypad_event_queue;

  localparam int unsigned DEPTH = 4;

  logic        Clk = 1'b0;
  logic        nReset;
  logic [23:0] button;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_down;
  logic [7:0]  switches;
  logic        overflow;
  logic        clr_ovf;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc;
  logic        exp_ovf = 1'b0;
  logic [3:0]  sb [$];

  keypad_event_queue #(.SAMPLE_DIV(4), .STABLE(3), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .nReset(nReset), .button(button), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_down(key_down),
    .switches(switches), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 Clk = ~Clk;

  // Edges since reset release; prescaler ticks land on multiples of 4
  always @(posedge Clk or negedge nReset) begin
    if (!nReset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard consumer: every accepted handshake must match the oldest expected code
  always @(negedge Clk) begin
    if (nReset === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
      if (sb.size() == 0) check("pop_unexpected", {28'd0, key_code}, 32'hFFFF_FFFF);
      else                check("pop_code", {28'd0, key_code}, {28'd0, sb.pop_front()});
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic align();
    edges(1);
    while (cyc % 4 != 0) edges(1);
  endtask

  // One debounced press and release with key_ready low
  task automatic press(input int code);
    align();
    button[code] = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(4'(code));
    else                   exp_ovf = 1'b1;
    edges(12);
    button[code] = 1'b0;
    edges(16);
  endtask

  task automatic drain(input string tag);
    key_ready = 1'b1;
    edges(DEPTH);
    check({tag, "_empty"}, {31'd0, key_valid}, 32'd0);
    check({tag, "_sb"}, sb.size(), 0);
    key_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    nReset = 1'b0; button = '0; key_ready = 1'b0; clr_ovf = 1'b0;
    edges(3);
    check("rst_code",  {28'd0, key_code},  32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_down",  {31'd0, key_down},  32'd0);
    check("rst_sw",    {24'd0, switches},  32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);

    // Key 5 held from reset release: deb sets on the 3rd tick edge (edge 12)
    button[5] = 1'b1;
    sb.push_back(4'd5);
    @(negedge Clk) nReset = 1'b1;
    repeat (11) @(posedge Clk);
    @(negedge Clk);
    check("k5_before", {31'd0, key_valid}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    check("k5_valid", {31'd0, key_valid}, 32'd1);
    check("k5_code",  {28'd0, key_code},  32'd5);
    check("k5_down",  {31'd0, key_down},  32'd1);
    @(posedge Clk); #1;
    button[5] = 1'b0;
    edges(16);
    check("k5_released", {31'd0, key_down}, 32'd0);
    drain("k5");

    // Glitch of 5 cycles on key 9 must never reach deb
    align();
    button[9] = 1'b1;
    edges(5);
    button[9] = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge Clk);
      if (key_valid || key_down) seen = 1;
    end
    check("glitch", seen, 0);

    // Keys 3 and 12 together: only code 3 is queued
    align();
    button[3] = 1'b1; button[12] = 1'b1;
    sb.push_back(4'd3);
    edges(12);
    check("dual_down", {31'd0, key_down}, 32'd1);
    button[3] = 1'b0; button[12] = 1'b0;
    edges(16);
    check("dual_valid", {31'd0, key_valid}, 32'd1);
    key_ready = 1'b1;
    edges(1);
    check("dual_single", {31'd0, key_valid}, 32'd0);
    edges(2);
    key_ready = 1'b0;
    check("dual_sb", sb.size(), 0);

    // Five presses into a 4-deep queue: last one dropped, overflow set
    press(4'hA); press(4'h0); press(4'hB); press(4'hC); press(4'hF);
    check("ovf_set", {31'd0, overflow}, {31'd0, exp_ovf});
    drain("ovf");
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    edges(1);
    clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_clr", {31'd0, overflow}, 32'd0);

    // Full queue with pop and push on the same edge: both succeed
    press(1); press(2); press(3); press(4);
    align();
    button[7] = 1'b1;
    sb.push_back(4'd7);
    edges(11);
    key_ready = 1'b1;
    edges(1);
    key_ready = 1'b0;
    button[7] = 1'b0;
    check("fullpp_ovf",   {31'd0, overflow},  32'd0);
    check("fullpp_valid", {31'd0, key_valid}, 32'd1);
    edges(16);
    drain("fullpp");

    // Switch levels after three ticks
    align();
    button[23:16] = 8'hA5;
    edges(11);
    check("sw_before", {24'd0, switches}, 32'd0);
    edges(1);
    check("sw_after", {24'd0, switches}, 32'hA5);
    check("sw_no_key", {31'd0, key_down}, 32'd0);

    // Reset while an entry is queued empties the FIFO immediately
    press(6);
    check("mid_valid", {31'd0, key_valid}, 32'd1);
    @(negedge Clk) nReset = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_code",  {28'd0, key_code},  32'd0);
    check("mid_rst_sw",    {24'd0, switches},  32'd0);
    edges(2);
    @(negedge Clk) nReset = 1'b1;
    edges(2);
    check("post_rst_ovf", {31'd0, overflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
